// File: rtl/apple1_uart_bridge_if.sv
// Apple-I PIA keyboard/display handshake bundle.
// master = bridge side, slave = PIA side.
interface apple1_uart_bridge_if;
    logic       kbd_rdy;
    logic       kbd_ack;
    logic [6:0] kbd_data;
    logic       dsp_rdy;
    logic       dsp_ack;
    logic [6:0] dsp_data;

    modport master (
        output kbd_rdy,
        output kbd_data,
        input  kbd_ack,
        input  dsp_rdy,
        input  dsp_data,
        output dsp_ack
    );

    modport slave (
        input  kbd_rdy,
        input  kbd_data,
        output kbd_ack,
        output dsp_rdy,
        output dsp_data,
        input  dsp_ack
    );
endinterface

// File: rtl/apple1_uart_bridge.sv
// UART <-> Apple-I PIA bridge: RX into keyboard FIFO,
// display characters out to TX with CR -> CR LF expansion.
module apple1_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic uart_rxd,
    output logic uart_txd,
    output logic rx_overrun,
    apple1_uart_bridge_if.master pia
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   F_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   F_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {K_IDLE, K_REQ, K_WAIT} kbd_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_ACK} tx_state_t;

    logic            rx_s1;
    logic            rx_s2;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sh;
    logic [6:0]      rx_byte;
    logic            rx_valid;

    logic [6:0]      norm_char;
    logic            norm_keep;

    logic [6:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    kbd_state_t      k_state;

    tx_state_t       tx_state;
    logic [9:0]      tx_sh;
    logic [3:0]      tx_bit;
    logic [CW-1:0]   tx_cnt;
    logic            tx_cr;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
        end
    end

    // RX deframer: mid-bit sampling, glitch and framing rejection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            unique case (rx_state)
                R_IDLE: begin
                    if (!rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == C_HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + C_ONE;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == C_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + C_ONE;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == C_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                        if (rx_s2) begin
                            rx_byte  <= rx_sh[6:0];
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + C_ONE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Map terminal characters onto Apple-I keyboard codes
    always_comb begin
        norm_char = rx_byte;
        norm_keep = rx_valid;
        if (rx_byte >= 7'h61 && rx_byte <= 7'h7A)
            norm_char = rx_byte - 7'h20;
        else if (rx_byte == 7'h7F || rx_byte == 7'h08)
            norm_char = 7'h5F;
        else if (rx_byte == 7'h0A)
            norm_keep = 1'b0;
    end

    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == F_FULL);
    assign pop   = (k_state == K_IDLE) && !empty && !pia.kbd_ack;
    assign push  = norm_keep && (!full || pop);

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= norm_char;
    end

    // FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + F_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - F_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (norm_keep && full && !pop)
                rx_overrun <= 1'b1;
        end
    end

    // Keyboard four-phase handshake towards the PIA
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_state      <= K_IDLE;
            pia.kbd_rdy  <= 1'b0;
            pia.kbd_data <= '0;
        end else begin
            unique case (k_state)
                K_IDLE: begin
                    if (pop) begin
                        pia.kbd_data <= mem[rd_ptr];
                        pia.kbd_rdy  <= 1'b1;
                        k_state      <= K_REQ;
                    end
                end
                K_REQ: begin
                    if (pia.kbd_ack) begin
                        pia.kbd_rdy <= 1'b0;
                        k_state     <= K_WAIT;
                    end
                end
                K_WAIT: begin
                    if (!pia.kbd_ack)
                        k_state <= K_IDLE;
                end
                default: k_state <= K_IDLE;
            endcase
        end
    end

    // Display handshake and TX serialiser; ack after last stop bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state    <= T_IDLE;
            tx_sh       <= '1;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            tx_cr       <= 1'b0;
            uart_txd    <= 1'b1;
            pia.dsp_ack <= 1'b0;
        end else begin
            uart_txd <= 1'b1;
            unique case (tx_state)
                T_IDLE: begin
                    if (pia.dsp_rdy) begin
                        tx_sh    <= {1'b1, 1'b0, pia.dsp_data, 1'b0};
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                        tx_cr    <= (pia.dsp_data == 7'h0D);
                        tx_state <= T_SEND;
                    end
                end
                T_SEND: begin
                    uart_txd <= tx_sh[0];
                    if (tx_bit == 4'd10) begin
                        // stop bit is now on the line; ack one cycle after it ends
                        if (tx_cnt == C_ONE) begin
                            pia.dsp_ack <= 1'b1;
                            tx_state    <= T_ACK;
                        end else begin
                            tx_cnt <= tx_cnt + C_ONE;
                        end
                    end else if (tx_cnt == C_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9 && tx_cr) begin
                            tx_sh  <= {1'b1, 8'h0A, 1'b0};
                            tx_bit <= '0;
                            tx_cr  <= 1'b0;
                        end else begin
                            tx_sh  <= {1'b1, tx_sh[9:1]};
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + C_ONE;
                    end
                end
                T_ACK: begin
                    if (!pia.dsp_rdy) begin
                        pia.dsp_ack <= 1'b0;
                        tx_state    <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apple1_uart_bridge.sv
// Directed bench for apple1_uart_bridge at 16 clocks per bit.
// Each task drives one scenario and checks its own results.
module tb_apple1_uart_bridge;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rxd;
    logic txd;
    logic overrun;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    apple1_uart_bridge_if pia ();

    assign rxd = loop_en ? txd : rxd_drv;

    apple1_uart_bridge #(
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rxd(rxd),
        .uart_txd(txd),
        .rx_overrun(overrun),
        .pia(pia)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            tick(16);
        end
        rxd_drv = stop;
        tick(16);
        rxd_drv = 1'b1;
    endtask

    task automatic wait_kbd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pia.kbd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_txd got=%b exp=1", txd);
        end
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_kbd_rdy got=%b exp=0", pia.kbd_rdy);
        end
        checks++;
        if (pia.dsp_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_dsp_ack got=%b exp=0", pia.dsp_ack);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_overrun got=%b exp=0", overrun);
        end
        checks++;
        if (pia.kbd_data !== 7'h00) begin
            failures++;
            $display("FAIL reset_kbd_data got=%h exp=00", pia.kbd_data);
        end
    endtask

    task automatic test_rx_basic;
        bit ok;
        tick(1);
        send_byte(8'h61, 1'b1);
        wait_kbd(ok);
        checks++;
        if (!ok || pia.kbd_data !== 7'h41) begin
            failures++;
            $display("FAIL rx_lower_a got=%h rdy=%b exp=41", pia.kbd_data, ok);
        end
        pia.kbd_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rx_ack_drop got=%b exp=0", pia.kbd_rdy);
        end
        tick(1);
        pia.kbd_ack = 1'b0;
        tick(2);

        send_byte(8'h7F, 1'b1);
        wait_kbd(ok);
        checks++;
        if (!ok || pia.kbd_data !== 7'h5F) begin
            failures++;
            $display("FAIL rx_del got=%h rdy=%b exp=5f", pia.kbd_data, ok);
        end
        pia.kbd_ack = 1'b1;
        tick(2);
        pia.kbd_ack = 1'b0;
        tick(2);

        send_byte(8'h0A, 1'b1);
        tick(40);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rx_lf_drop got=%b exp=0", pia.kbd_rdy);
        end

        send_byte(8'h88, 1'b1);
        wait_kbd(ok);
        checks++;
        if (!ok || pia.kbd_data !== 7'h5F) begin
            failures++;
            $display("FAIL rx_bs_bit7 got=%h rdy=%b exp=5f", pia.kbd_data, ok);
        end
        pia.kbd_ack = 1'b1;
        tick(2);
        pia.kbd_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_ack_violation;
        bit ok;
        pia.kbd_ack = 1'b1;
        send_byte(8'h7A, 1'b1);
        tick(10);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle_pop got=%b exp=0", pia.kbd_rdy);
        end
        pia.kbd_ack = 1'b0;
        wait_kbd(ok);
        checks++;
        if (!ok || pia.kbd_data !== 7'h5A) begin
            failures++;
            $display("FAIL ack_idle_data got=%h rdy=%b exp=5a", pia.kbd_data, ok);
        end
        pia.kbd_ack = 1'b1;
        tick(2);
        pia.kbd_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_rx_buffer;
        bit ok;
        logic [6:0] exp;
        for (int i = 0; i < 6; i++)
            send_byte(8'h41 + 8'(i), 1'b1);
        tick(4);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL buf_overrun got=%b exp=1", overrun);
        end
        for (int i = 0; i < 5; i++) begin
            exp = 7'h41 + 7'(i);
            wait_kbd(ok);
            checks++;
            if (!ok || pia.kbd_data !== exp) begin
                failures++;
                $display("FAIL buf_order%0d got=%h rdy=%b exp=%h",
                         i, pia.kbd_data, ok, exp);
            end
            pia.kbd_ack = 1'b1;
            tick(2);
            pia.kbd_ack = 1'b0;
            tick(1);
        end
        tick(40);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL buf_sixth got=%b exp=0", pia.kbd_rdy);
        end
    endtask

    task automatic test_rx_errors;
        rxd_drv = 1'b0;
        tick(4);
        rxd_drv = 1'b1;
        tick(200);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rx_glitch got=%b exp=0", pia.kbd_rdy);
        end
        send_byte(8'h41, 1'b0);
        tick(200);
        checks++;
        if (pia.kbd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rx_framing got=%b exp=0", pia.kbd_rdy);
        end
    endtask

    task automatic test_tx;
        logic [0:9] w;
        bit seen;
        int t0;
        int t1;
        w = 10'b0001110101;
        pia.dsp_data = 7'h5C;
        pia.dsp_rdy = 1'b1;
        seen = 1'b0;
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        t0 = cyc;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tx_start got=%b exp=0", txd);
        end
        pia.dsp_data = 7'h00;
        for (int i = 0; i < 10; i++) begin
            while (cyc < t0 + 16 * i + 8) @(negedge clk);
            checks++;
            if (txd !== w[i]) begin
                failures++;
                $display("FAIL tx_bit%0d got=%b exp=%b", i, txd, w[i]);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pia.dsp_ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t1 = cyc;
        checks++;
        if (!seen || t1 - t0 != 161) begin
            failures++;
            $display("FAIL tx_ack_time got=%0d exp=161", t1 - t0);
        end
        pia.dsp_rdy = 1'b0;
        tick(2);
        @(negedge clk);
        checks++;
        if (pia.dsp_ack !== 1'b0) begin
            failures++;
            $display("FAIL tx_ack_fall got=%b exp=0", pia.dsp_ack);
        end
        tick(3);
    endtask

    task automatic test_tx_cr;
        logic [0:19] w;
        bit seen;
        int t0;
        int t1;
        w = 20'b0101100001_0010100001;
        pia.dsp_data = 7'h0D;
        pia.dsp_rdy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        t0 = cyc;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL cr_start got=%b exp=0", txd);
        end
        for (int i = 0; i < 20; i++) begin
            while (cyc < t0 + 16 * i + 8) @(negedge clk);
            checks++;
            if (txd !== w[i]) begin
                failures++;
                $display("FAIL cr_bit%0d got=%b exp=%b", i, txd, w[i]);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pia.dsp_ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t1 = cyc;
        checks++;
        if (!seen || t1 - t0 < 318 || t1 - t0 > 322) begin
            failures++;
            $display("FAIL cr_ack_time got=%0d exp=320+-2", t1 - t0);
        end
        pia.dsp_rdy = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_midframe;
        pia.dsp_data = 7'h41;
        pia.dsp_rdy = 1'b1;
        rxd_drv = 1'b0;
        tick(40);
        reset = 1'b0;
        #2;
        checks++;
        if (txd !== 1'b1 || pia.dsp_ack !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_tx got=%b%b exp=10", txd, pia.dsp_ack);
        end
        checks++;
        if (pia.kbd_rdy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_rx got=%b%b exp=00",
                     pia.kbd_rdy, overrun);
        end
        pia.dsp_rdy = 1'b0;
        rxd_drv = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(3);
    endtask

    task automatic test_loopback;
        logic [6:0] msg [5];
        msg[0] = 7'h48;
        msg[1] = 7'h45;
        msg[2] = 7'h4C;
        msg[3] = 7'h4C;
        msg[4] = 7'h4F;
        loop_en = 1'b1;
        tick(2);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    pia.dsp_data = msg[i];
                    pia.dsp_rdy = 1'b1;
                    for (int j = 0; j < 400; j++) begin
                        @(negedge clk);
                        if (pia.dsp_ack === 1'b1) break;
                    end
                    pia.dsp_rdy = 1'b0;
                    for (int j = 0; j < 10; j++) begin
                        @(negedge clk);
                        if (pia.dsp_ack === 1'b0) break;
                    end
                end
            end
            begin
                bit ok;
                for (int k = 0; k < 5; k++) begin
                    ok = 1'b0;
                    for (int j = 0; j < 400; j++) begin
                        @(negedge clk);
                        if (pia.kbd_rdy === 1'b1) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    checks++;
                    if (!ok || pia.kbd_data !== msg[k]) begin
                        failures++;
                        $display("FAIL loop%0d got=%h rdy=%b exp=%h",
                                 k, pia.kbd_data, ok, msg[k]);
                    end
                    pia.kbd_ack = 1'b1;
                    tick(2);
                    pia.kbd_ack = 1'b0;
                    tick(1);
                end
            end
        join
        loop_en = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL loop_overrun got=%b exp=0", overrun);
        end
    endtask

    initial begin
        pia.kbd_ack = 1'b0;
        pia.dsp_rdy = 1'b0;
        pia.dsp_data = 7'h00;
        test_reset();
        test_rx_basic();
        test_ack_violation();
        test_rx_buffer();
        test_rx_errors();
        test_tx();
        test_tx_cr();
        test_reset_midframe();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
